// File: rtl/dlx_bus_pkg.sv
// dlx_bus_pkg : shared state encoding and constants for the DLX bus initiator (rev 1.0)
`default_nettype none

package dlx_bus_pkg;

    localparam int DATA_W          = 32;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_RECOVER = 2'd2
    } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/dlx_bus_timeout.sv
// dlx_bus_timeout : clear/enable cycle counter with terminal-count flag (rev 1.0)
`default_nettype none

module dlx_bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Counter holds k-1 before the k-th edge spent in BUS, so this fires on edge TIMEOUT.
    assign terminal = (count == 8'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/dlx_bus_master.sv
// dlx_bus_master : single-word DLX bus initiator with ACK wait and timeout abort (rev 1.0)
`default_nettype none

module dlx_bus_master
    import dlx_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [DATA_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RESP_VALID,
    output logic [DATA_W-1:0] RESP_RDATA,
    output logic              RESP_ERR,
    output logic              AS_N,
    output logic              WR_N,
    output logic [DATA_W-1:0] MAO,
    output logic [DATA_W-1:0] MDO,
    input  logic              ACK_N,
    input  logic [DATA_W-1:0] DI
);

    bus_state_t state;
    logic       accept;
    logic       tmo_terminal;

    assign accept = (state == ST_IDLE) && REQ_VALID && REQ_READY;

    dlx_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (CLK),
        .rst      (RST),
        .clear    (accept),
        .enable   (state == ST_BUS),
        .terminal (tmo_terminal)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            AS_N       <= 1'b1;
            WR_N       <= 1'b1;
            MAO        <= '0;
            MDO        <= '0;
            RESP_VALID <= 1'b0;
            RESP_ERR   <= 1'b0;
            RESP_RDATA <= '0;
            REQ_READY  <= 1'b1;
        end else begin
            RESP_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        MAO       <= REQ_ADDR;
                        MDO       <= REQ_WDATA;
                        WR_N      <= ~REQ_WE;
                        AS_N      <= 1'b0;
                        REQ_READY <= 1'b0;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // An acknowledge on the timeout edge still completes the access normally.
                    if (!ACK_N) begin
                        if (WR_N) begin
                            RESP_RDATA <= DI;
                        end
                        AS_N       <= 1'b1;
                        WR_N       <= 1'b1;
                        RESP_VALID <= 1'b1;
                        RESP_ERR   <= 1'b0;
                        state      <= ST_RECOVER;
                    end else if (tmo_terminal) begin
                        AS_N       <= 1'b1;
                        WR_N       <= 1'b1;
                        RESP_VALID <= 1'b1;
                        RESP_ERR   <= 1'b1;
                        RESP_RDATA <= '0;
                        state      <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    REQ_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    AS_N      <= 1'b1;
                    WR_N      <= 1'b1;
                    REQ_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dlx_bus_master.md
# dlx_bus_master

Bus initiator for the DLX external memory/IO bus. Accepts single-word read/write requests from the core-side memory stage and drives the AS_N/WR_N/MAO/MDO strobes. It then waits for the responder's active-low ACK_N pulse, captures read data, and returns a one-cycle response to the core. A timeout watchdog ensures that a missing responder cannot hang the core.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles in BUS state without ACK_N before abort; legal range 4..255.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  core request strobe.
- REQ_READY  out  1  high only in IDLE; request is accepted on the edge where REQ_VALID & REQ_READY.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  32  word address.
- REQ_WDATA  in  32  write data.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_RDATA  out  32  read data; valid with RESP_VALID for reads. Holds its value until the next response.
- RESP_ERR  out  1  valid with RESP_VALID; 1 = timeout.
- AS_N  out  1  address strobe, active low.
- WR_N  out  1  write strobe, active low.
- MAO  out  32  bus address.
- MDO  out  32  bus write data.
- ACK_N  in  1  responder acknowledge, active low; a pulse of one or more cycles.
- DI  in  32  responder read data; meaningful only while ACK_N=0 and WR_N=1.

## Operation
- States: IDLE, BUS, RECOVER.
- IDLE:
  - AS_N=1, WR_N=1, REQ_READY=1.
  - On accept, register REQ_ADDR into MAO and REQ_WDATA into MDO.
  - Set WR_N=~REQ_WE, AS_N=0, clear the timeout counter, and go to BUS.
- BUS:
  - AS_N, WR_N, MAO and MDO are held constant for the whole state; WR_N never toggles mid-transaction.
  - Counter increments each cycle.
  - ACK_N=0 sampled:
    - For a read, latch DI into RESP_RDATA.
    - Set AS_N=1 and WR_N=1, RESP_VALID=1, RESP_ERR=0, and go to RECOVER.
  - Counter reaches TIMEOUT-1 with ACK_N=1:
    - Set AS_N=1 and WR_N=1, RESP_VALID=1, RESP_ERR=1, RESP_RDATA=0, and go to RECOVER.
  - ACK_N wins if it is sampled low on the same edge that the timeout is reached.
- RECOVER:
  - Exactly one cycle with AS_N=1, which guarantees the responder sees a strobe gap.
  - RESP_VALID is high during this cycle only. The state then returns to IDLE.
- ACK_N=0 sampled in IDLE or RECOVER is ignored; no response is produced and there is no error.
- REQ_VALID while not ready is not accepted. The core must hold the request stable until it is accepted.
- Reset values:
  - State = IDLE.
  - AS_N=1, WR_N=1, MAO=0, MDO=0.
  - RESP_VALID=0, RESP_ERR=0, RESP_RDATA=0, REQ_READY=1 once reset is released.
- Reset asserted mid-BUS:
  - Strobes are released immediately (asynchronously).
  - No response is issued and the transaction is dropped.

## Timing
- Accept edge E0: AS_N=0 is visible after E0.
- With a responder that asserts ACK_N low after its third edge seeing AS_N=0 (E1..E3), ACK_N is sampled low at E4.
- RESP_VALID is high in the cycle E4–E5. IDLE resumes after E5, so REQ_READY is high again in E5–E6.
- Minimum transaction period = ack latency + 3 cycles; with a 3-cycle responder this is 6 cycles accept-to-accept.
- Write data commit: the responder writes on E4. MDO and WR_N=0 are guaranteed stable from after E0 through E4.
- Read capture: DI is sampled on the same edge that ACK_N is first seen low. There is no extra pipeline stage.
- Timeout: with no ACK, RESP_VALID with RESP_ERR=1 appears in the cycle after edge E0+TIMEOUT.
- All outputs are registered; there are no combinational paths from ACK_N/DI to the bus outputs.

## Structure
- Shared package dlx_bus_pkg holds:
  - The state encoding (IDLE, BUS, RECOVER).
  - Address/data width constant 32.
  - Default TIMEOUT.
- One natural sub-module, dlx_bus_timeout: a clear/enable counter with a terminal-count flag, parameterised by TIMEOUT.

## Test plan
- Read, 3-cycle responder, memory[0x10]=0xDEADBEEF: accept read 0x10 → AS_N low for 4 cycles, WR_N=1 throughout, RESP_VALID one cycle with RESP_RDATA=0xDEADBEEF, RESP_ERR=0.
- Write 0x10←0x12345678, then read 0x10 → WR_N=0 and MDO stable through the ack edge; the read returns 0x12345678; an AS_N=1 gap of ≥1 cycle occurs between the transactions.
- Back-to-back reads with REQ_VALID held high → accept-to-accept exactly 6 cycles; REQ_READY low in BUS/RECOVER.
- No responder (ACK_N tied 1), TIMEOUT=16 → RESP_VALID with RESP_ERR=1, RESP_RDATA=0 exactly 16 cycles after the accept edge; AS_N returns to 1.
- RST pulsed two cycles into BUS → AS_N=WR_N=1 immediately, no RESP_VALID; the next request completes normally.
- ACK_N pulsed low while in IDLE → no state change and no RESP_VALID.
